// File: rtl/data_mem_pkg.sv
// Shared funct3 encodings, FSM states and access-legality helpers for the sub-word data memory.
// Pure declarations; no timing or flow control lives here.
package data_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      F3_H, F3_HU: return lane[0];
      F3_W:        return lane != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Stores have no unsigned variants, so only B/H/W are legal for them.
  function automatic logic f3_illegal(input logic write, input logic [2:0] f3);
    if (write) return !(f3 inside {F3_B, F3_H, F3_W});
    return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

endpackage

// File: rtl/data_mem_subword_align.sv
// Lane steering: store byte enables and replicated data, load lane select with extension.
// Purely combinational, zero latency, no flow control.
module subword_align
  import data_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_byte = rword[7:0];
    case (addr_lo)
      2'd1:    lane_byte = rword[15:8];
      2'd2:    lane_byte = rword[23:16];
      2'd3:    lane_byte = rword[31:24];
      default: ;
    endcase
    lane_half = addr_lo[1] ? rword[31:16] : rword[15:0];

    load_data = rword;
    case (funct3)
      F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_BU:   load_data = {24'h0, lane_byte};
      F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
      F3_HU:   load_data = {16'h0, lane_half};
      default: ;
    endcase
  end

  assign misalign = is_misaligned(funct3, addr_lo);

endmodule

// File: rtl/data_mem_subword.sv
// Data memory with RISC-V byte/half/word access; response is registered, one cycle after acceptance.
// req_ready is low only during the post-reset clear sweep; responses cannot be stalled.
module data_mem_subword
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS    = 1024,
  parameter int ADDR_W         = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic              init_done
);

  localparam int     IDX_W     = $clog2(DEPTH_WORDS);
  localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_INIT : ST_READY;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clear_cnt_q, clear_cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_error_q, rsp_error_d;
  logic             rsp_load_q, rsp_load_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       lane_q, lane_d;
  logic [31:0]      rd_word_q;
  logic [31:0]      mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic             range_err, req_err, accept, wr_en;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata, ld_data;
  logic             st_misalign;
  logic [31:0]      unused_st_load;
  logic [3:0]       unused_ld_be;
  logic [31:0]      unused_ld_wdata;
  logic             unused_ld_misalign;

  assign req_ready = (state_q == ST_READY);
  assign init_done = (state_q == ST_READY);

  subword_align u_store_align (
    .funct3    (req_funct3),
    .addr_lo   (req_addr[1:0]),
    .wdata     (req_wdata),
    .rword     (32'h0),
    .be        (st_be),
    .wdata_rep (st_wdata),
    .load_data (unused_st_load),
    .misalign  (st_misalign)
  );

  // Second instance extends the word captured at acceptance using that request's lane info.
  subword_align u_load_align (
    .funct3    (f3_q),
    .addr_lo   (lane_q),
    .wdata     (32'h0),
    .rword     (rd_word_q),
    .be        (unused_ld_be),
    .wdata_rep (unused_ld_wdata),
    .load_data (ld_data),
    .misalign  (unused_ld_misalign)
  );

  always_comb begin
    idx       = req_addr[IDX_W+1:2];
    range_err = |req_addr[ADDR_W-1:IDX_W+2];
    req_err   = range_err | st_misalign | f3_illegal(req_write, req_funct3);
    accept    = req_valid && req_ready && !reset;
    wr_en     = accept && req_write && !req_err;
  end

  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    if (state_q == ST_INIT) begin
      clear_cnt_d = clear_cnt_q + 1'b1;
      if (clear_cnt_q == IDX_W'(DEPTH_WORDS - 1)) state_d = ST_READY;
    end
  end

  always_comb begin
    rsp_valid_d = accept;
    rsp_error_d = accept && req_err;
    rsp_load_d  = accept && !req_write && !req_err;
    f3_d        = accept ? req_funct3 : f3_q;
    lane_d      = accept ? req_addr[1:0] : lane_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RST_STATE;
      clear_cnt_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_load_q  <= 1'b0;
      f3_q        <= F3_W;
      lane_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_load_q  <= rsp_load_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
    end
  end

  // Storage carries no reset; the sweep or earlier stores define its contents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == ST_INIT) begin
        mem_q[clear_cnt_q] <= '0;
      end else if (wr_en) begin
        for (int b = 0; b < 4; b++) begin
          if (st_be[b]) mem_q[idx][8*b +: 8] <= st_wdata[8*b +: 8];
        end
      end
      if (accept && !req_write) rd_word_q <= mem_q[idx];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_load_q ? ld_data : 32'h0;

endmodule

// File: tb/tb_data_mem_subword.sv
// Directed bench for data_mem_subword: stimulus pushes expected responses, a forked monitor pops and compares.
module tb_data_mem_subword;
  import data_mem_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        init_done;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  data_mem_subword #(
    .DEPTH_WORDS    (1024),
    .ADDR_W         (32),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .init_done  (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  // Called just after a rising edge; returns just after the acceptance edge.
  task automatic issue(input string nm, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] want_rd, input logic want_err);
    exp_t e;
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    chk({nm, "_ready"}, {31'h0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    e.name  = nm;
    e.rdata = want_rd;
    e.err   = want_err;
    e.cyc   = cyc;
    sb.push_back(e);
    req_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (req_ready) break;
    end
    if (!req_ready) n = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = F3_W;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;

    fork
      begin : monitor
        exp_t m;
        forever begin
          @(negedge clk);
          if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
            end else begin
              m = sb.pop_front();
              chk({m.name, "_rdata"}, rsp_rdata, m.rdata);
              chk({m.name, "_err"}, {31'h0, rsp_error}, {31'h0, m.err});
              chk({m.name, "_cyc"}, 32'(cyc), 32'(m.cyc));
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'h0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_error", {31'h0, rsp_error}, 32'd0);
    chk("rst_init_done", {31'h0, init_done}, 32'd0);
    reset = 1'b0;

    wait_ready(n);
    chk("sweep1_len", 32'(n), 32'd1024);
    chk("sweep1_init_done", {31'h0, init_done}, 32'd1);

    issue("lw_3fc",      1'b0, F3_W,   32'h3FC,  32'h0,        32'h0000_0000, 1'b0);
    issue("sw_10",       1'b1, F3_W,   32'h10,   32'hDEADBEEF, 32'h0,         1'b0);
    issue("lw_10_a",     1'b0, F3_W,   32'h10,   32'h0,        32'hDEADBEEF,  1'b0);
    issue("sb_13",       1'b1, F3_B,   32'h13,   32'hAAAAAA80, 32'h0,         1'b0);
    issue("lw_10_b",     1'b0, F3_W,   32'h10,   32'h0,        32'h80ADBEEF,  1'b0);
    issue("lb_13",       1'b0, F3_B,   32'h13,   32'h0,        32'hFFFFFF80,  1'b0);
    issue("lbu_13",      1'b0, F3_BU,  32'h13,   32'h0,        32'h00000080,  1'b0);
    issue("sh_10",       1'b1, F3_H,   32'h10,   32'hFFFF1234, 32'h0,         1'b0);
    issue("lh_10",       1'b0, F3_H,   32'h10,   32'h0,        32'h00001234,  1'b0);
    issue("err_lh_11",   1'b0, F3_H,   32'h11,   32'h0,        32'h0,         1'b1);
    issue("err_sw_12",   1'b1, F3_W,   32'h12,   32'hFFFFFFFF, 32'h0,         1'b1);
    issue("err_lw_1000", 1'b0, F3_W,   32'h1000, 32'h0,        32'h0,         1'b1);
    issue("err_ld_f3_3", 1'b0, 3'b011, 32'h10,   32'h0,        32'h0,         1'b1);
    issue("err_st_f3_4", 1'b1, F3_BU,  32'h10,   32'hFFFFFFFF, 32'h0,         1'b1);
    issue("lw_10_c",     1'b0, F3_W,   32'h10,   32'h0,        32'h80AD1234,  1'b0);
    issue("lhu_12",      1'b0, F3_HU,  32'h12,   32'h0,        32'h000080AD,  1'b0);
    issue("lh_12",       1'b0, F3_H,   32'h12,   32'h0,        32'hFFFF80AD,  1'b0);
    issue("lb_11",       1'b0, F3_B,   32'h11,   32'h0,        32'h00000012,  1'b0);
    issue("lbu_10",      1'b0, F3_BU,  32'h10,   32'h0,        32'h00000034,  1'b0);
    issue("sw_ffc",      1'b1, F3_W,   32'hFFC,  32'h11223344, 32'h0,         1'b0);
    issue("lw_ffc",      1'b0, F3_W,   32'hFFC,  32'h0,        32'h11223344,  1'b0);
    issue("lh_ffe",      1'b0, F3_H,   32'hFFE,  32'h0,        32'h00001122,  1'b0);

    // Store accepted, then reset on the very next edge: its response must be cut short.
    issue("sw_pend",     1'b1, F3_W,   32'h20,   32'hCAFEF00D, 32'h0,         1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("pend_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("pend_req_ready", {31'h0, req_ready}, 32'd0);
    reset = 1'b0;

    repeat (500) @(posedge clk);
    #1;
    chk("mid_init_ready", {31'h0, req_ready}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_ready(n);
    chk("sweep2_len", 32'(n), 32'd1024);

    issue("lw_ffc_clr",  1'b0, F3_W,   32'hFFC,  32'h0,        32'h0,         1'b0);
    issue("lw_20_clr",   1'b0, F3_W,   32'h20,   32'h0,        32'h0,         1'b0);
    issue("lw_10_clr",   1'b0, F3_W,   32'h10,   32'h0,        32'h0,         1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_subword.md
Name: data_mem_subword

Overview:
- Parametrised successor to the core's word-only data memory.
- Adds RISC-V sub-word loads and stores: byte and halfword accesses, with sign or zero extension on loads.
- Uses a valid/ready request port and a registered one-cycle response.
- Detects misaligned, out-of-range and illegal-funct3 accesses; clears the array after reset with a sweep FSM.
- Sits between the core's MEM stage and the backing storage array.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of two, ≥ 2.
- ADDR_W, 32: byte-address width.
- CLEAR_ON_RESET, 1: 1 = zero every word after reset via a sweep; 0 = contents are left untouched and the block goes ready immediately.

Ports:
- clk  in  1  rising-edge clock; the only clock in the block.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; the value is taken from the low bits.
- rsp_valid  out  1  one-cycle pulse, one per accepted request.
- rsp_rdata  out  32  load result after extension; 0 for stores and for errors.
- rsp_error  out  1  the request was rejected; no state changed.
- init_done  out  1  high once the clear sweep has finished.

Behaviour:
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, init_done=0.
  - Clear counter=0.
  - State=INIT if CLEAR_ON_RESET, else READY.
- Reset handling:
  - Reset is sampled only on the rising edge of clk.
  - A request presented on a reset edge is ignored.
- FSM, state INIT:
  - Each cycle writes 0 to word[clear_cnt] and increments clear_cnt.
  - When clear_cnt reaches DEPTH_WORDS-1 and that word is written, next state is READY.
  - INIT therefore lasts exactly DEPTH_WORDS cycles after reset deasserts.
- FSM, state READY:
  - init_done=1 and req_ready=1, both combinational from state.
  - No other states exist.
- Acceptance:
  - A request is accepted on a rising edge where req_valid && req_ready.
  - Throughput is 1 request per cycle.
  - There is no response backpressure; the consumer must always take the response.
- Response timing: for a request accepted at edge N, rsp_valid=1 during the cycle following edge N, together with rsp_rdata and rsp_error. Otherwise rsp_valid=0.
- Addressing:
  - word index = req_addr[ADDR_W-1:2].
  - Out of range when index ≥ DEPTH_WORDS.
- Errors: rsp_error=1, rsp_rdata=0 and no array write for any of:
  - out-of-range address;
  - H/HU access with addr[0]=1;
  - W access with addr[1:0]≠0;
  - load funct3 in {011,110,111};
  - store funct3 not in {000,001,010}.
- Store write enables:
  - SB: byte enable = 1<<addr[1:0], data = {4{wdata[7:0]}}.
  - SH: enable = 0011 or 1100 by addr[1], data = {2{wdata[15:0]}}.
  - SW: enable = 1111.
  - Only enabled bytes of the word change.
- Loads:
  - The aligned word is read at the acceptance edge.
  - The lane is selected by addr[1:0].
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- Ordering: the store is committed at its acceptance edge, so a store followed by a load of the same word in the next cycle returns the new data. There is no hazard stall.
- Reset mid-operation:
  - Reset during INIT restarts the sweep at word 0.
  - Reset while a response is pending forces rsp_valid=0 at the reset edge; the response is lost.
  - A store already committed before the reset edge remains in the array; with CLEAR_ON_RESET=1 the sweep then overwrites it.
- Array read port: the array has no asynchronous read.

Decomposition:
- Package data_mem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum {ST_INIT, ST_READY};
  - the function checking alignment and legality of funct3.
- One combinational sub-module, subword_align, is natural:
  - inputs funct3, addr[1:0], wdata and the raw read word;
  - outputs byte enables, replicated store data, extended load data and a misalign flag.

Test Plan:
- Reset sweep: release reset, DEPTH_WORDS=1024 → req_ready rises exactly 1024 cycles after reset deasserts, init_done=1; then LW 0x3FC → rdata 0x00000000, error 0.
- Word round trip: SW 0xDEADBEEF @0x10, next cycle LW @0x10 → rsp_rdata 0xDEADBEEF one cycle after acceptance, rsp_valid a single pulse.
- Sub-word store and extension: SB 0x80 @0x13 → LW @0x10 = 0x80ADBEEF, LB @0x13 = 0xFFFFFF80, LBU @0x13 = 0x00000080. SH 0x1234 @0x10 → LH @0x10 = 0x00001234.
- Errors: LH @0x11, SW @0x12, LW @0x1000 (index 1024), load funct3=011 → each gives rsp_error=1 and rdata 0; a following LW @0x10 still shows 0x80AD1234.
- Reset mid-INIT: assert reset at sweep cycle 500 → req_ready stays 0 and becomes 1 exactly 1024 cycles after the second reset deasserts.
- Reset with a pending response: accept SW @0x20 and assert reset on the next edge → rsp_valid=0 after that edge.
